// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access, data first, with a per-transaction watchdog.
module mem_arbiter #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] if_data,
  output logic [15:0] dm_rdata,
  output logic        if_valid,
  output logic        dm_valid,
  output logic        stall_if,
  output logic        pipe_wen,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;
  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);
  state_t     state;
  logic [7:0] wait_cnt;
  assign pipe_wen = ~(dm_req & ~dm_valid);
  assign stall_if = (if_req & ~if_valid) | ~pipe_wen;
  // A valid cycle blocks the grant so the requester can drop or renew its request first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_data   <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      err       <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: if (!(if_valid || dm_valid) && (dm_req || if_req)) begin
          state     <= dm_req ? DM_BUSY : IF_BUSY;
          mem_en    <= 1'b1;
          mem_wr    <= dm_req & dm_wr;
          mem_addr  <= dm_req ? dm_addr : if_addr;
          mem_wdata <= dm_req ? dm_wdata : 16'h0000;
          wait_cnt  <= '0;
        end
        IF_BUSY, DM_BUSY: begin
          if (!mem_ready)
            wait_cnt <= wait_cnt + 8'd1;
          // Ready on the final watchdog cycle still wins over the abort.
          if (mem_ready || wait_cnt == LAST) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            if (!mem_ready)
              err <= 1'b1;
            if (state == IF_BUSY) begin
              if_valid <= 1'b1;
              if_data  <= mem_ready ? mem_rdata : 16'h0000;
            end else begin
              dm_valid <= 1'b1;
              if (!mem_wr || !mem_ready)
                dm_rdata <= mem_ready ? mem_rdata : 16'h0000;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard-driven checks of arbitration, latency, watchdog and reset behaviour.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_wr = 1'b0, mem_ready = 1'b0;
  logic [15:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic        mem_en, mem_wr, if_valid, dm_valid, stall_if, pipe_wen, err;
  logic [15:0] mem_addr, mem_wdata, if_data, dm_rdata;
  typedef struct {bit dm; logic [15:0] data;} exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .dm_req(dm_req), .dm_wr(dm_wr),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .if_data(if_data),
    .dm_rdata(dm_rdata), .if_valid(if_valid), .dm_valid(dm_valid), .stall_if(stall_if),
    .pipe_wen(pipe_wen), .err(err)
  );

  // Plays the memory side: raises mem_ready on the ready_at-th mem_en cycle (0 = never).
  task automatic run_xact(input int ready_at, input logic [15:0] rdata, input int budget,
                          output int n_en, output bit got_if, output bit got_dm);
    n_en = 0; got_if = 0; got_dm = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (if_valid || dm_valid) begin
        got_if = if_valid; got_dm = dm_valid; mem_ready = 1'b0;
        return;
      end
      if (mem_en) begin
        n_en++; if_req = 1'b0; dm_req = 1'b0;
      end
      mem_ready = mem_en && n_en == ready_at;
      mem_rdata = rdata;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (mem_en !== 1'b0 || mem_wr !== 1'b0) begin failures++; $display("FAIL reset_en got en=%b wr=%b exp 0 0", mem_en, mem_wr); end
    checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin failures++; $display("FAIL reset_addr got %h/%h exp 0000/0000", mem_addr, mem_wdata); end
    checks++; if (if_data !== 16'h0 || dm_rdata !== 16'h0) begin failures++; $display("FAIL reset_data got %h/%h exp 0000/0000", if_data, dm_rdata); end
    checks++; if (if_valid !== 1'b0 || dm_valid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_flags got %b%b%b exp 000", if_valid, dm_valid, err); end
    checks++; if (pipe_wen !== 1'b1 || stall_if !== 1'b0) begin failures++; $display("FAIL reset_pipe got wen=%b stall=%b exp 1 0", pipe_wen, stall_if); end
    rst = 1'b1;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0010;
    sb.push_back('{1'b0, 16'hA123});
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0010 || mem_wr !== 1'b0) begin failures++; $display("FAIL fetch_issue got en=%b addr=%h wr=%b exp 1 0010 0", mem_en, mem_addr, mem_wr); end
    checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL fetch_stall got %b exp 1", stall_if); end
    mem_ready = 1'b1; mem_rdata = 16'hA123; if_req = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (mem_en !== 1'b0 || if_valid !== 1'b1) begin failures++; $display("FAIL fetch_done got en=%b if_valid=%b exp 0 1", mem_en, if_valid); end
    if (if_valid) begin
      e = sb.pop_front();
      checks++; if (e.dm || if_data !== e.data) begin failures++; $display("FAIL fetch_data got %h exp %h", if_data, e.data); end
    end
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL fetch_pulse got %b exp 0", if_valid); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0200; if_req = 1'b1; if_addr = 16'h0004;
    sb.push_back('{1'b1, 16'h5555});
    sb.push_back('{1'b0, 16'h1234});
    #1;
    checks++; if (pipe_wen !== 1'b0 || stall_if !== 1'b1) begin failures++; $display("FAIL prio_hold got wen=%b stall=%b exp 0 1", pipe_wen, stall_if); end
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0200 || mem_wr !== 1'b0) begin failures++; $display("FAIL prio_first got en=%b addr=%h wr=%b exp 1 0200 0", mem_en, mem_addr, mem_wr); end
    checks++; if (pipe_wen !== 1'b0) begin failures++; $display("FAIL prio_busy_wen got %b exp 0", pipe_wen); end
    mem_ready = 1'b1; mem_rdata = 16'h5555;
    @(negedge clk);
    checks++; if (dm_valid !== 1'b1 || pipe_wen !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("FAIL prio_dm_done got valid=%b wen=%b en=%b exp 1 1 0", dm_valid, pipe_wen, mem_en); end
    if (dm_valid) begin
      e = sb.pop_front();
      checks++; if (!e.dm || dm_rdata !== e.data) begin failures++; $display("FAIL prio_dm_data got %h exp %h", dm_rdata, e.data); end
    end
    dm_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL prio_gap got en=%b exp 0", mem_en); end
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0004) begin failures++; $display("FAIL prio_fetch got en=%b addr=%h exp 1 0004", mem_en, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 16'h1234; if_req = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL prio_if_valid got %b exp 1", if_valid); end
    if (if_valid) begin
      e = sb.pop_front();
      checks++; if (e.dm || if_data !== e.data) begin failures++; $display("FAIL prio_if_data got %h exp %h", if_data, e.data); end
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0300; dm_wdata = 16'hBEEF;
    sb.push_back('{1'b1, 16'h5555});
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++; if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0300 || mem_wdata !== 16'hBEEF) begin failures++; $display("FAIL write_hold cyc=%0d got en=%b wr=%b addr=%h wdata=%h exp 1 1 0300 beef", i, mem_en, mem_wr, mem_addr, mem_wdata); end
      if (i == 1) begin dm_addr = 16'hFFFF; dm_wdata = 16'h0000; end
      if (i == 4) begin mem_ready = 1'b1; mem_rdata = 16'hDEAD; dm_req = 1'b0; end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (dm_valid !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("FAIL write_done got valid=%b en=%b exp 1 0", dm_valid, mem_en); end
    if (dm_valid) begin
      e = sb.pop_front();
      checks++; if (!e.dm || dm_rdata !== e.data) begin failures++; $display("FAIL write_rdata got %h exp %h", dm_rdata, e.data); end
    end
  endtask

  task automatic test_boundary_and_watchdog();
    int n; bit gi, gd;
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0030;
    sb.push_back('{1'b0, 16'h7E57});
    run_xact(15, 16'h7E57, 40, n, gi, gd);
    checks++; if (!gi || n != 15) begin failures++; $display("FAIL edge_ready got valid=%b en_cycles=%0d exp 1 15", gi, n); end
    if (gi) begin
      e = sb.pop_front();
      checks++; if (if_data !== e.data || err !== 1'b0) begin failures++; $display("FAIL edge_data got %h err=%b exp %h 0", if_data, err, e.data); end
    end
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0020;
    sb.push_back('{1'b0, 16'h0000});
    run_xact(0, 16'hFFFF, 40, n, gi, gd);
    checks++; if (!gi || n != 15) begin failures++; $display("FAIL wdog_abort got valid=%b en_cycles=%0d exp 1 15", gi, n); end
    if (gi) begin
      e = sb.pop_front();
      checks++; if (if_data !== e.data || err !== 1'b1) begin failures++; $display("FAIL wdog_data got %h err=%b exp %h 1", if_data, err, e.data); end
    end
    @(negedge clk);
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0500;
    sb.push_back('{1'b1, 16'h6666});
    run_xact(1, 16'h6666, 10, n, gi, gd);
    checks++; if (!gd) begin failures++; $display("FAIL sticky_valid got %b exp 1", gd); end
    if (gd) begin
      e = sb.pop_front();
      checks++; if (dm_rdata !== e.data || err !== 1'b1) begin failures++; $display("FAIL sticky_err got %h err=%b exp %h 1", dm_rdata, err, e.data); end
    end
  endtask

  task automatic test_async_reset();
    int n; bit gi, gd;
    @(negedge clk);
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0400; dm_wdata = 16'h1111;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL rst_pre got en=%b exp 1", mem_en); end
    #2 rst = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin failures++; $display("FAIL rst_async got en=%b wr=%b addr=%h wdata=%h exp 0 0 0000 0000", mem_en, mem_wr, mem_addr, mem_wdata); end
    checks++; if (err !== 1'b0 || if_data !== 16'h0 || dm_rdata !== 16'h0) begin failures++; $display("FAIL rst_clear got err=%b if=%h dm=%h exp 0 0000 0000", err, if_data, dm_rdata); end
    dm_req = 1'b0;
    @(negedge clk);
    checks++; if (dm_valid !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL rst_no_valid got %b%b exp 00", dm_valid, if_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (dm_valid !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL rst_after got valid=%b en=%b exp 0 0", dm_valid, mem_en); end
    if_req = 1'b1; if_addr = 16'h0050;
    sb.push_back('{1'b0, 16'h0BAD});
    run_xact(2, 16'h0BAD, 10, n, gi, gd);
    checks++; if (!gi || n != 2) begin failures++; $display("FAIL rst_restart got valid=%b en_cycles=%0d exp 1 2", gi, n); end
    if (gi) begin
      e = sb.pop_front();
      checks++; if (if_data !== e.data) begin failures++; $display("FAIL rst_restart_data got %h exp %h", if_data, e.data); end
    end
  endtask

  task automatic test_ignore();
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 16'hCCCC;
    repeat (2) begin
      @(negedge clk);
      checks++; if (if_valid !== 1'b0 || dm_valid !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL idle_ready got %b%b en=%b exp 00 0", if_valid, dm_valid, mem_en); end
    end
    mem_ready = 1'b0; if_req = 1'b1; if_addr = 16'h0040;
    sb.push_back('{1'b0, 16'h4444});
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0040) begin failures++; $display("FAIL ign_issue got en=%b addr=%h exp 1 0040", mem_en, mem_addr); end
    if_addr = 16'h0099;
    @(negedge clk);
    checks++; if (mem_addr !== 16'h0040) begin failures++; $display("FAIL ign_addr got %h exp 0040", mem_addr); end
    mem_ready = 1'b1; mem_rdata = 16'h4444; if_req = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL ign_valid got %b exp 1", if_valid); end
    if (if_valid) begin
      e = sb.pop_front();
      checks++; if (if_data !== e.data) begin failures++; $display("FAIL ign_data got %h exp %h", if_data, e.data); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_write();
    test_boundary_and_watchdog();
    test_async_reset();
    test_ignore();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_drain got %0d left exp 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
